// File: rtl/uart_packet_pkg.sv
// Shared definitions for the UART packet deframer (rx) and framer (tx).
//   PacketState       : parser/framer state encoding
//   DEFAULT_SYNC_BYTE : first byte of every packet
package uart_packet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    LEN,
    PAYLOAD,
    CHECK
  } PacketState;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

endpackage

// File: rtl/uart_packet_timeout.sv
// Inter-byte timeout: loadable down-counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   restart_i     : reload the counter (a byte arrived)
//   enable_i      : count down (a packet is in progress)
//   expired_o     : one-cycle pulse on the TIMEOUT_CYCLES-th idle cycle after the last reload
module uart_packet_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = LoadVal;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // A reload in the same cycle suppresses expiry: the arriving byte wins.
  assign expired_o = enable_i && !restart_i && (count_q == CntW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_packet_rx.sv
// Packet deframer fed by a UART receiver byte stream.
// Parses SYNC, DEST, SRC, LEN header, then forwards LEN payload bytes with SoP/EoP markers.
// Optional feature macro PACKET_CHECKSUM_EN: a trailing 8-bit sum byte is checked and opError
// pulses on mismatch; when undefined opError is tied low.
//   ipClk, ipReset        : clock, asynchronous active-low reset
//   ipRxData, ipRxValid   : incoming byte and its one-cycle strobe
//   opDestination/opSource/opLength, opHeaderValid : header fields and update pulse
//   opData, opValid, opSoP, opEoP : payload stream
//   opTimeout, opError    : abort pulse, checksum mismatch pulse
// All outputs are registered: a response appears one cycle after the ipRxValid cycle.
module uart_packet_rx
  import uart_packet_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 43400
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opDestination,
  output logic [7:0] opSource,
  output logic [7:0] opLength,
  output logic       opHeaderValid,
  output logic [7:0] opData,
  output logic       opValid,
  output logic       opSoP,
  output logic       opEoP,
  output logic       opTimeout,
  output logic       opError
);

`ifdef PACKET_CHECKSUM_EN
  localparam PacketState EndState = CHECK;
`else
  localparam PacketState EndState = IDLE;
`endif

  PacketState state_q, state_d;
  logic [7:0] dest_q, dest_d, src_q, src_d, len_q, len_d;
  logic [7:0] data_q, data_d, remaining_q, remaining_d;
  logic       hv_q, hv_d, valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic       timeout_q, timeout_d;
  logic       expired;

  uart_packet_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (ipClk),
    .rst_ni   (ipReset),
    .restart_i(ipRxValid),
    .enable_i (state_q != IDLE),
    .expired_o(expired)
  );

  // State register
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (ipRxValid) begin
      unique case (state_q)
        IDLE:    if (ipRxData == SYNC_BYTE) state_d = DEST;
        DEST:    state_d = SRC;
        SRC:     state_d = LEN;
        LEN:     state_d = (ipRxData == 8'd0) ? EndState : PAYLOAD;
        PAYLOAD: if (remaining_q == 8'd1) state_d = EndState;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      state_d = IDLE;
    end
  end

`ifdef PACKET_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       error_q, error_d;
`endif

  // Outputs and datapath next-state
  always_comb begin
    dest_d      = dest_q;
    src_d       = src_q;
    len_d       = len_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    hv_d        = 1'b0;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    timeout_d   = 1'b0;
`ifdef PACKET_CHECKSUM_EN
    sum_d       = sum_q;
    error_d     = 1'b0;
`endif
    if (ipRxValid) begin
      unique case (state_q)
        DEST: begin
          dest_d = ipRxData;
`ifdef PACKET_CHECKSUM_EN
          sum_d  = ipRxData;
`endif
        end
        SRC: begin
          src_d = ipRxData;
`ifdef PACKET_CHECKSUM_EN
          sum_d = sum_q + ipRxData;
`endif
        end
        LEN: begin
          len_d       = ipRxData;
          remaining_d = ipRxData;
          hv_d        = 1'b1;
`ifdef PACKET_CHECKSUM_EN
          sum_d       = sum_q + ipRxData;
`endif
        end
        PAYLOAD: begin
          valid_d     = 1'b1;
          data_d      = ipRxData;
          // remaining still equals the length only on the first payload byte
          sop_d       = (remaining_q == len_q);
          eop_d       = (remaining_q == 8'd1);
          remaining_d = remaining_q - 8'd1;
`ifdef PACKET_CHECKSUM_EN
          sum_d       = sum_q + ipRxData;
`endif
        end
`ifdef PACKET_CHECKSUM_EN
        CHECK: error_d = (ipRxData != sum_q);
`endif
        default: ;
      endcase
    end else if (expired) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      dest_q      <= '0;
      src_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      hv_q        <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      dest_q      <= dest_d;
      src_q       <= src_d;
      len_q       <= len_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      hv_q        <= hv_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef PACKET_CHECKSUM_EN
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end
  assign opError = error_q;
`else
  assign opError = 1'b0;
`endif

  assign opDestination = dest_q;
  assign opSource      = src_q;
  assign opLength      = len_q;
  assign opHeaderValid = hv_q;
  assign opData        = data_q;
  assign opValid       = valid_q;
  assign opSoP         = sop_q;
  assign opEoP         = eop_q;
  assign opTimeout     = timeout_q;

endmodule
